data_sram_resp: RTL and testbench

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

---
 rtl/data_sram_resp_pkg.sv | 19 +
 rtl/data_sram_resp_if.sv | 27 ++
 rtl/data_sram_resp_fifo.sv | 66 ++++++
 rtl/data_sram_resp.sv | 51 +++++
 tb/tb_data_sram_resp.sv | 123 ++++++++++++
 5 files changed

// File: rtl/data_sram_resp_pkg.sv
// rtl/data_sram_resp_pkg.sv - shared widths, size encodings and defaults for the data SRAM responder
package data_sram_resp_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = 4;

  localparam int DEF_ADDR_BITS = 10;
  localparam int DEF_QDEPTH    = 2;
  localparam int DEF_LAT       = 2;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } sram_size_e;

endpackage

// File: rtl/data_sram_resp_if.sv
// rtl/data_sram_resp_if.sv - request/response bus between the memory stage and the data SRAM
interface data_sram_resp_if;
  import data_sram_resp_pkg::*;

  logic              data_sram_req;
  logic              data_sram_wr;
  logic [1:0]        data_sram_size;
  logic [STRB_W-1:0] data_sram_wstrb;
  logic [ADDR_W-1:0] data_sram_addr;
  logic [DATA_W-1:0] data_sram_wdata;
  logic              data_sram_addr_ok;
  logic              data_sram_data_ok;
  logic [DATA_W-1:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

endinterface

// File: rtl/data_sram_resp_fifo.sv
// rtl/data_sram_resp_fifo.sv - in-order response queue with a per-entry latency countdown
module resp_fifo
  import data_sram_resp_pkg::*;
#(
  parameter int QDEPTH = DEF_QDEPTH,
  parameter int LAT    = DEF_LAT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic              push_wr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              stall,
  output logic              not_full,
  output logic              data_ok,
  output logic [DATA_W-1:0] rdata
);

  localparam int PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int OCC_W  = $clog2(QDEPTH + 1);
  localparam logic [OCC_W-1:0] FULL     = OCC_W'(QDEPTH);
  localparam logic [PTR_W-1:0] LAST     = PTR_W'(QDEPTH - 1);
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LAT - 1);

  logic              wr_q   [QDEPTH];
  logic [DATA_W-1:0] data_q [QDEPTH];
  logic [CNT_W-1:0]  cnt_q  [QDEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [OCC_W-1:0]  count;

  // Readiness depends only on registered occupancy, so a pop frees a slot next cycle.
  assign not_full = resetn && (count < FULL);
  assign data_ok  = (count != '0) && (cnt_q[rd_ptr] == '0) && !stall;
  assign rdata    = (data_ok && !wr_q[rd_ptr]) ? data_q[rd_ptr] : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        wr_q[i]   <= 1'b0;
        data_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (push && wr_ptr == PTR_W'(i)) begin
          wr_q[i]   <= push_wr;
          data_q[i] <= push_data;
          cnt_q[i]  <= LAT_INIT;
        end else if (cnt_q[i] != '0) begin
          cnt_q[i] <= cnt_q[i] - 1'b1;
        end
      end
      if (push)    wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (data_ok) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({push, data_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/data_sram_resp.sv
// rtl/data_sram_resp.sv - word-addressed data SRAM with byte strobes and in-order delayed responses
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int QDEPTH    = DEF_QDEPTH,
  parameter int LAT       = DEF_LAT
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   resp_stall,
  data_sram_resp_if.slave        bus
);

  logic [DATA_W-1:0]    mem [0:(1 << ADDR_BITS) - 1];
  logic [ADDR_BITS-1:0] idx;
  logic                 accept;
  logic [DATA_W-1:0]    rd_word;
  logic                 unused_bits;

  // Upper address bits alias onto the array; size is a hint for the core only.
  assign idx         = bus.data_sram_addr[ADDR_BITS+1:2];
  assign unused_bits = ^{bus.data_sram_size, bus.data_sram_addr[ADDR_W-1:ADDR_BITS+2],
                         bus.data_sram_addr[1:0]};
  assign accept      = bus.data_sram_req && bus.data_sram_addr_ok;
  assign rd_word     = mem[idx];

  always_ff @(posedge clk) begin
    if (accept && bus.data_sram_wr) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (bus.data_sram_wstrb[i]) mem[idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
      end
    end
  end

  resp_fifo #(
    .QDEPTH (QDEPTH),
    .LAT    (LAT)
  ) u_resp_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (accept),
    .push_wr   (bus.data_sram_wr),
    .push_data (bus.data_sram_wr ? '0 : rd_word),
    .stall     (resp_stall),
    .not_full  (bus.data_sram_addr_ok),
    .data_ok   (bus.data_sram_data_ok),
    .rdata     (bus.data_sram_rdata)
  );

endmodule

// File: tb/tb_data_sram_resp.sv
// tb/tb_data_sram_resp.sv - directed checks of data_sram_resp at LAT=2 and LAT=1
module tb_data_sram_resp;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic stall0 = 1'b0;
  logic stall1 = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  data_sram_resp_if b0 ();
  data_sram_resp_if b1 ();

  data_sram_resp #(.ADDR_BITS(10), .QDEPTH(2), .LAT(2)) u_dut (
    .clk(clk), .resetn(resetn), .resp_stall(stall0), .bus(b0)
  );

  data_sram_resp #(.ADDR_BITS(10), .QDEPTH(2), .LAT(1)) u_dut_lat1 (
    .clk(clk), .resetn(resetn), .resp_stall(stall1), .bus(b1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive inputs, check outputs at the falling edge, advance past the rising edge.
  task automatic cyc(input int sel, input string tag, input bit req, input bit wr,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                     input bit stall, input bit e_aok, input bit e_dok, input logic [31:0] e_rd);
    if (sel == 0) begin
      b0.data_sram_req = req;  b0.data_sram_wr = wr;  b0.data_sram_addr = addr;
      b0.data_sram_wdata = wdata;  b0.data_sram_wstrb = strb;  stall0 = stall;
    end else begin
      b1.data_sram_req = req;  b1.data_sram_wr = wr;  b1.data_sram_addr = addr;
      b1.data_sram_wdata = wdata;  b1.data_sram_wstrb = strb;  stall1 = stall;
    end
    @(negedge clk);
    if (sel == 0) begin
      check({tag, ".aok"}, {31'd0, b0.data_sram_addr_ok}, {31'd0, e_aok});
      check({tag, ".dok"}, {31'd0, b0.data_sram_data_ok}, {31'd0, e_dok});
      check({tag, ".rd"},  b0.data_sram_rdata, e_rd);
    end else begin
      check({tag, ".aok"}, {31'd0, b1.data_sram_addr_ok}, {31'd0, e_aok});
      check({tag, ".dok"}, {31'd0, b1.data_sram_data_ok}, {31'd0, e_dok});
      check({tag, ".rd"},  b1.data_sram_rdata, e_rd);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    b0.data_sram_req = 1'b0;  b0.data_sram_wr = 1'b0;  b0.data_sram_size = 2'd2;
    b0.data_sram_wstrb = 4'h0;  b0.data_sram_addr = '0;  b0.data_sram_wdata = '0;
    b1.data_sram_req = 1'b0;  b1.data_sram_wr = 1'b0;  b1.data_sram_size = 2'd2;
    b1.data_sram_wstrb = 4'h0;  b1.data_sram_addr = '0;  b1.data_sram_wdata = '0;

    // reset state
    cyc(0, "rst0", 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 32'h0);
    cyc(0, "rst1", 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 32'h0);
    resetn = 1'b1;
    cyc(0, "st10",   1, 1, 32'h10, 32'hAABBCCDD, 4'hF, 0, 1, 0, 32'h0);
    cyc(0, "ld10",   1, 0, 32'h10, 32'h0,        4'h0, 0, 1, 0, 32'h0);
    cyc(0, "st_rsp", 0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 1, 32'h0);
    cyc(0, "ld_rsp", 0, 0, 32'h0,  32'h0,        4'h0, 0, 1, 1, 32'hAABBCCDD);

    // byte store into the top lane
    cyc(0, "stb13",   1, 1, 32'h13, 32'h11000000, 4'h8, 0, 1, 0, 32'h0);
    cyc(0, "ld10b",   1, 0, 32'h10, 32'h0,        4'h0, 0, 1, 0, 32'h0);
    cyc(0, "stb_rsp", 0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 1, 32'h0);
    cyc(0, "ldb_rsp", 0, 0, 32'h0,  32'h0,        4'h0, 0, 1, 1, 32'h11BBCCDD);

    // aliasing: 0x1000 wraps to word 0
    cyc(0, "st1000",  1, 1, 32'h1000, 32'h12345678, 4'hF, 0, 1, 0, 32'h0);
    cyc(0, "ld0",     1, 0, 32'h0,    32'h0,        4'h0, 0, 1, 0, 32'h0);
    cyc(0, "sta_rsp", 0, 0, 32'h0,    32'h0,        4'h0, 0, 0, 1, 32'h0);
    cyc(0, "lda_rsp", 0, 0, 32'h0,    32'h0,        4'h0, 0, 1, 1, 32'h12345678);

    // full queue under stall, then in-order drain
    cyc(0, "fq_a",  1, 0, 32'h10, 32'h0, 4'h0, 1, 1, 0, 32'h0);
    cyc(0, "fq_b",  1, 0, 32'h0,  32'h0, 4'h0, 1, 1, 0, 32'h0);
    cyc(0, "fq_c",  1, 0, 32'h4,  32'h0, 4'h0, 1, 0, 0, 32'h0);
    cyc(0, "fq_d",  1, 0, 32'h4,  32'h0, 4'h0, 1, 0, 0, 32'h0);
    cyc(0, "fq_r1", 0, 0, 32'h0,  32'h0, 4'h0, 0, 0, 1, 32'h11BBCCDD);
    cyc(0, "fq_r2", 0, 0, 32'h0,  32'h0, 4'h0, 0, 1, 1, 32'h12345678);
    cyc(0, "fq_e",  0, 0, 32'h0,  32'h0, 4'h0, 0, 1, 0, 32'h0);

    // reset with two entries outstanding
    cyc(0, "rs_st", 1, 1, 32'h8,  32'hCAFEF00D, 4'hF, 0, 1, 0, 32'h0);
    cyc(0, "rs_ld", 1, 0, 32'h10, 32'h0,        4'h0, 0, 1, 0, 32'h0);
    resetn = 1'b0;
    cyc(0, "rs_h0", 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 32'h0);
    cyc(0, "rs_h1", 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 32'h0);
    resetn = 1'b1;
    cyc(0, "rs_q0", 0, 0, 32'h0,  32'h0, 4'h0, 0, 1, 0, 32'h0);
    cyc(0, "rs_q1", 0, 0, 32'h0,  32'h0, 4'h0, 0, 1, 0, 32'h0);
    cyc(0, "rs_l8", 1, 0, 32'h8,  32'h0, 4'h0, 0, 1, 0, 32'h0);
    cyc(0, "rs_lx", 1, 0, 32'h10, 32'h0, 4'h0, 0, 1, 0, 32'h0);
    cyc(0, "rs_r8", 0, 0, 32'h0,  32'h0, 4'h0, 0, 0, 1, 32'hCAFEF00D);
    cyc(0, "rs_rx", 0, 0, 32'h0,  32'h0, 4'h0, 0, 1, 1, 32'h11BBCCDD);

    // LAT=1: preload four words, then stream four loads at one per cycle
    cyc(1, "l1_s0", 1, 1, 32'h0, 32'h11111111, 4'hF, 0, 1, 0, 32'h0);
    cyc(1, "l1_s1", 1, 1, 32'h4, 32'h22222222, 4'hF, 0, 1, 1, 32'h0);
    cyc(1, "l1_s2", 1, 1, 32'h8, 32'h33333333, 4'hF, 0, 1, 1, 32'h0);
    cyc(1, "l1_s3", 1, 1, 32'hC, 32'h44444444, 4'hF, 0, 1, 1, 32'h0);
    cyc(1, "l1_l0", 1, 0, 32'h0, 32'h0, 4'h0, 0, 1, 1, 32'h0);
    cyc(1, "l1_l1", 1, 0, 32'h4, 32'h0, 4'h0, 0, 1, 1, 32'h11111111);
    cyc(1, "l1_l2", 1, 0, 32'h8, 32'h0, 4'h0, 0, 1, 1, 32'h22222222);
    cyc(1, "l1_l3", 1, 0, 32'hC, 32'h0, 4'h0, 0, 1, 1, 32'h33333333);
    cyc(1, "l1_r3", 0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 1, 32'h44444444);
    cyc(1, "l1_e",  0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
